// File: rtl/hamming_pkg.sv
// hamming_pkg: sizing helpers and data-bit position lookup shared by the Hamming decoder.
package hamming_pkg;
    localparam int MAX_PAR_BITS = 6;
    typedef logic [MAX_PAR_BITS-1:0] syn_max_t;
    function automatic int par_bits_to_n(input int r);
        return (1 << r) - 1;
    endfunction
    function automatic int par_bits_to_k(input int r);
        return par_bits_to_n(r) - r;
    endfunction
    function automatic bit is_pow2(input int i);
        return (i > 0) && ((i & (i - 1)) == 0);
    endfunction
    // Codeword position of the j-th data bit (j-th non-power-of-2 position).
    function automatic int data_pos(input int j);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int i = 1; i < 128; i++) begin
            if (!is_pow2(i)) begin
                if (cnt == j && pos == 0) pos = i;
                cnt++;
            end
        end
        return pos;
    endfunction
endpackage

// File: rtl/hamming_onehot_dec.sv
// hamming_onehot_dec: SEL_W-to-OUT_W one-hot decoder; output bit g is set for select value g+1,
// so a zero select gives an all-zero output.
module hamming_onehot_dec #(
    parameter int SEL_W = 3,
    parameter int OUT_W = (1 << SEL_W) - 1
) (
    input  logic [SEL_W-1:0] i_sel,
    output logic [OUT_W-1:0] o_onehot
);
    for (genvar i = 0; i < OUT_W; i++) begin : g_dec
        assign o_onehot[i] = (i_sel == SEL_W'(i + 1));
    end
endmodule

// File: rtl/hamming_sec_pipe.sv
// hamming_sec_pipe: two-stage Hamming SEC decoder with valid/ready on both sides and a saturating
// error counter. Define HAMM_DED_EN to use bit 0 as overall parity for double-error detection.
module hamming_sec_pipe
    import hamming_pkg::*;
#(
    parameter int PAR_BITS = 3,
    parameter int CNT_W    = 8,
    localparam int N       = par_bits_to_n(PAR_BITS),
    localparam int K       = par_bits_to_k(PAR_BITS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N:0]          in_code,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N:0]          out_code,
    output logic [K-1:0]        out_data,
    output logic [PAR_BITS-1:0] out_syndrome,
    output logic                out_err,
    output logic                out_dbl_err,
    output logic [CNT_W-1:0]    err_count,
    input  logic                clr_count
);
    logic                r_v1, r_v2;
    logic [N:0]          r_code1, r_code2;
    logic [PAR_BITS-1:0] r_syn1, r_syn2;
    logic [K-1:0]        r_data2;
    logic                r_err2, r_dbl2;
    logic [CNT_W-1:0]    r_cnt;
    logic                w_ld1, w_ld2;
    logic [PAR_BITS-1:0] w_syn;
    logic [N-1:0]        w_mask;
    logic [N:0]          w_fixed;
    logic [K-1:0]        w_data;
    logic                w_err, w_dbl;

    // A stage loads when empty or when its word leaves in the same cycle.
    assign w_ld2    = !r_v2 || out_ready;
    assign w_ld1    = !r_v1 || w_ld2;
    assign in_ready = w_ld1;

    always_comb begin
        w_syn = '0;
        for (int i = 1; i <= N; i++)
            if (in_code[i]) w_syn = w_syn ^ PAR_BITS'(i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_code1 <= '0;
            r_syn1  <= '0;
        end else if (w_ld1) begin
            r_v1    <= in_valid;
            r_code1 <= in_code;
            r_syn1  <= w_syn;
        end
    end

    hamming_onehot_dec #(.SEL_W(PAR_BITS), .OUT_W(N)) u_dec (
        .i_sel    (r_syn1),
        .o_onehot (w_mask)
    );

`ifdef HAMM_DED_EN
    logic r_par1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_par1 <= 1'b0;
        else if (w_ld1) r_par1 <= ^in_code;
    end
    // Even overall parity with a nonzero syndrome means two flips: report, do not touch.
    assign w_err   = (r_syn1 != '0) || r_par1;
    assign w_dbl   = (r_syn1 != '0) && !r_par1;
    assign w_fixed = r_code1 ^ {(w_dbl ? {N{1'b0}} : w_mask), (r_syn1 == '0) && r_par1};
`else
    assign w_err   = r_syn1 != '0;
    assign w_dbl   = 1'b0;
    assign w_fixed = r_code1 ^ {w_mask, 1'b0};
`endif

    for (genvar j = 0; j < K; j++) begin : g_data
        assign w_data[j] = w_fixed[data_pos(j)];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2    <= 1'b0;
            r_code2 <= '0;
            r_data2 <= '0;
            r_syn2  <= '0;
            r_err2  <= 1'b0;
            r_dbl2  <= 1'b0;
        end else if (w_ld2) begin
            r_v2    <= r_v1;
            r_code2 <= w_fixed;
            r_data2 <= w_data;
            r_syn2  <= r_syn1;
            r_err2  <= w_err;
            r_dbl2  <= w_dbl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                         r_cnt <= '0;
        else if (clr_count)                                 r_cnt <= '0;
        else if (r_v2 && out_ready && r_err2 && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
    end

    assign out_valid    = r_v2;
    assign out_code     = r_code2;
    assign out_data     = r_data2;
    assign out_syndrome = r_syn2;
    assign out_err      = r_err2;
    assign out_dbl_err  = r_dbl2;
    assign err_count    = r_cnt;
endmodule

// File: tb/tb_hamming_sec_pipe.sv
// tb_hamming_sec_pipe: directed and randomized checks of hamming_sec_pipe (R=3) against a
// behavioural decoder model; HAMM_DED_EN selects the matching model.
module tb_hamming_sec_pipe;
    logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, clr_count = 1'b0;
    logic       in_ready, out_valid, out_err, out_dbl_err;
    logic [7:0] in_code = 8'h00, out_code, err_count;
    logic [3:0] out_data;
    logic [2:0] out_syndrome;
    int         n_tests = 0, n_fail = 0;

    typedef struct {
        logic [7:0] code;
        logic [3:0] data;
        logic [2:0] syn;
        logic       err;
        logic       dbl;
    } ref_t;

    hamming_sec_pipe #(.PAR_BITS(3), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code), .out_data(out_data),
        .out_syndrome(out_syndrome), .out_err(out_err), .out_dbl_err(out_dbl_err),
        .err_count(err_count), .clr_count(clr_count)
    );

    always #5 clk = ~clk;

    function automatic ref_t ref_decode(input logic [7:0] c);
        ref_t r;
        int   s;
        int   k;
        s = 0;
        k = 0;
        for (int i = 1; i < 8; i++) if (c[i]) s = s ^ i;
        r.code = c;
        r.syn  = 3'(s);
`ifdef HAMM_DED_EN
        begin
            bit p;
            p = ^c;
            r.err = (s != 0) || p;
            r.dbl = (s != 0) && !p;
            if (s != 0 && p) r.code[s] = !c[s];
            if (s == 0 && p) r.code[0] = !c[0];
        end
`else
        r.err = s != 0;
        r.dbl = 1'b0;
        if (s != 0) r.code[s] = !c[s];
`endif
        r.data = '0;
        for (int i = 1; i < 8; i++)
            if (i != 1 && i != 2 && i != 4) begin
                r.data[k] = r.code[i];
                k++;
            end
        return r;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_count = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_one(input logic [7:0] c);
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; in_code = c;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, in_ready, err_count, out_code, out_err, out_dbl_err} !== {1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: valid=%b ready=%b cnt=%h code=%h err=%b dbl=%b, want 0 1 00 00 0 0",
                     out_valid, in_ready, err_count, out_code, out_err, out_dbl_err);
        end
    endtask

    task automatic test_clean();
        do_reset();
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; in_code = 8'hCC;
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clean_latency: out_valid=%b after 1 cycle, want 0", out_valid); end
        @(negedge clk);
        n_tests++;
        if ({out_valid, out_code, out_data, out_syndrome, out_err, out_dbl_err, err_count} !== {1'b1, 8'hCC, 4'b1101, 3'b000, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL clean: v=%b code=%h data=%b syn=%b err=%b dbl=%b cnt=%0d, want 1 cc 1101 000 0 0 0",
                     out_valid, out_code, out_data, out_syndrome, out_err, out_dbl_err, err_count);
        end
        @(negedge clk);
        n_tests++;
        if ({out_valid, err_count} !== {1'b0, 8'h00}) begin
            n_fail++; $display("FAIL clean_count: v=%b cnt=%0d, want 0 0", out_valid, err_count);
        end
    endtask

    task automatic test_correct();
        do_reset();
        send_one(8'hEC);
        n_tests++;
        if ({out_valid, out_code, out_data, out_syndrome, out_err, out_dbl_err} !== {1'b1, 8'hCC, 4'b1101, 3'b101, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL correct: v=%b code=%h data=%b syn=%b err=%b dbl=%b, want 1 cc 1101 101 1 0",
                     out_valid, out_code, out_data, out_syndrome, out_err, out_dbl_err);
        end
        @(negedge clk);
        n_tests++;
        if (err_count !== 8'd1) begin n_fail++; $display("FAIL correct_count: cnt=%0d want 1", err_count); end
    endtask

    task automatic test_double();
        logic [7:0] want_code;
        logic       want_dbl;
`ifdef HAMM_DED_EN
        want_code = 8'hCA; want_dbl = 1'b1;
`else
        want_code = 8'hC2; want_dbl = 1'b0;
`endif
        do_reset();
        send_one(8'hCA);
        n_tests++;
        if ({out_valid, out_code, out_syndrome, out_err, out_dbl_err} !== {1'b1, want_code, 3'b011, 1'b1, want_dbl}) begin
            n_fail++;
            $display("FAIL double: v=%b code=%h syn=%b err=%b dbl=%b, want 1 %h 011 1 %b",
                     out_valid, out_code, out_syndrome, out_err, out_dbl_err, want_code, want_dbl);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w[5];
        ref_t       e;
        logic [7:0] held;
        bit         hv;
        int         sent, got;
        do_reset();
        for (int i = 0; i < 5; i++) w[i] = 8'($urandom);
        sent = 0; got = 0; hv = 1'b0; held = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (hv) begin
                n_tests++;
                if (out_valid !== 1'b1 || out_code !== held) begin
                    n_fail++; $display("FAIL b2b_stable: v=%b code=%h, want 1 %h", out_valid, out_code, held);
                end
            end
            out_ready = (c >= 4);
            in_valid  = (sent < 5);
            in_code   = w[sent % 5];
            #1;
            if (c == 3) begin
                n_tests++;
                if (sent !== 2 || in_ready !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_fill: accepted=%0d in_ready=%b, want 2 0", sent, in_ready);
                end
            end
            if (out_valid && out_ready) begin
                e = ref_decode(w[got % 5]);
                n_tests++;
                if (got >= 5 || out_code !== e.code || out_data !== e.data) begin
                    n_fail++; $display("FAIL b2b_order: idx=%0d code=%h data=%b, want %h %b", got, out_code, out_data, e.code, e.data);
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
            hv = out_valid && !out_ready;
            held = out_code;
        end
        in_valid = 1'b0;
        n_tests++;
        if (got !== 5) begin n_fail++; $display("FAIL b2b_count: delivered=%0d want 5", got); end
    endtask

    task automatic test_saturate();
        do_reset();
        out_ready = 1'b1;
        repeat (255) begin
            @(negedge clk);
            in_valid = 1'b1; in_code = 8'hCC ^ (8'd1 << $urandom_range(1, 7));
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (err_count !== 8'd255) begin n_fail++; $display("FAIL sat_255: cnt=%0d want 255", err_count); end
        repeat (2) begin
            @(negedge clk);
            in_valid = 1'b1; in_code = 8'hCC ^ (8'd1 << $urandom_range(1, 7));
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (err_count !== 8'd255) begin n_fail++; $display("FAIL sat_hold: cnt=%0d want 255", err_count); end
        @(negedge clk);
        in_valid = 1'b1; in_code = 8'hEC;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({out_valid, out_err} !== 2'b11) begin n_fail++; $display("FAIL clr_setup: v=%b err=%b want 1 1", out_valid, out_err); end
        clr_count = 1'b1;
        @(negedge clk);
        clr_count = 1'b0;
        n_tests++;
        if (err_count !== 8'd0) begin n_fail++; $display("FAIL clr_wins: cnt=%0d want 0", err_count); end
        send_one(8'hEC);
        @(negedge clk);
        n_tests++;
        if (err_count !== 8'd1) begin n_fail++; $display("FAIL clr_recount: cnt=%0d want 1", err_count); end
    endtask

    task automatic test_random_stream();
        ref_t       q[$];
        ref_t       e;
        int         mcnt;
        logic [7:0] held;
        bit         hv;
        do_reset();
        mcnt = 0; hv = 1'b0; held = '0;
        for (int c = 0; c < 420; c++) begin
            @(negedge clk);
            n_tests++;
            if (err_count !== 8'(mcnt)) begin n_fail++; $display("FAIL rnd_count: cyc=%0d cnt=%0d want %0d", c, err_count, mcnt); end
            if (hv) begin
                n_tests++;
                if (out_valid !== 1'b1 || out_code !== held) begin
                    n_fail++; $display("FAIL rnd_stable: cyc=%0d v=%b code=%h want 1 %h", c, out_valid, out_code, held);
                end
            end
            if (c < 400) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_code   = 8'($urandom);
                out_ready = ($urandom_range(0, 3) != 0);
                clr_count = ($urandom_range(0, 40) == 0);
            end else begin
                in_valid = 1'b0; out_ready = 1'b1; clr_count = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_extra: unexpected word code=%h", out_code);
                end else begin
                    e = q.pop_front();
                    if ({out_code, out_data, out_syndrome, out_err, out_dbl_err} !== {e.code, e.data, e.syn, e.err, e.dbl}) begin
                        n_fail++;
                        $display("FAIL rnd_word: code=%h data=%b syn=%b err=%b dbl=%b, want %h %b %b %b %b",
                                 out_code, out_data, out_syndrome, out_err, out_dbl_err, e.code, e.data, e.syn, e.err, e.dbl);
                    end
                    if (!clr_count && e.err && mcnt < 255) mcnt++;
                end
            end
            if (clr_count) mcnt = 0;
            if (in_valid && in_ready) q.push_back(ref_decode(in_code));
            hv = out_valid && !out_ready;
            held = out_code;
        end
        n_tests++;
        if (q.size() != 0) begin n_fail++; $display("FAIL rnd_drain: %0d words lost, want 0", q.size()); end
    endtask

    task automatic test_async_reset();
        bit seen;
        do_reset();
        send_one(8'hEC);
        @(negedge clk);
        n_tests++;
        if (err_count !== 8'd1) begin n_fail++; $display("FAIL ar_setup_cnt: cnt=%0d want 1", err_count); end
        out_ready = 1'b0; in_valid = 1'b1; in_code = 8'h3C;
        @(negedge clk);
        in_code = 8'h5A;
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++;
        if ({out_valid, in_ready} !== 2'b10) begin n_fail++; $display("FAIL ar_full: v=%b ready=%b want 1 0", out_valid, in_ready); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, in_ready, err_count} !== {1'b1 ^ 1'b1, 1'b1, 8'h00}) begin
            n_fail++; $display("FAIL ar_async: v=%b ready=%b cnt=%0d want 0 1 0", out_valid, in_ready, err_count);
        end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_tests++;
        if ({seen, err_count} !== {1'b0, 8'h00}) begin n_fail++; $display("FAIL ar_release: valid_seen=%b cnt=%0d want 0 0", seen, err_count); end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_correct();
        test_double();
        test_back_to_back();
        test_saturate();
        test_random_stream();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/hamming_sec_pipe.md
Name: hamming_sec_pipe

Overview:
Parametrised, pipelined Hamming single-error-correcting decoder with valid/ready handshake on both sides.
- Computes the syndrome of a received codeword and decodes it to a one-hot flip mask (a generalised N-output decoder).
- Corrects the flagged bit, extracts data bits, and counts corrected words.
- Sits between the channel/receive register and the data consumer in the Hamming datapath.

Parameters:
PAR_BITS, 3, number of Hamming parity bits R; codeword length N = 2^R-1, data length K = N-R (R=3 gives 7/4; legal 2..6)
CNT_W, 8, width of saturating error counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input word valid
in_ready  out  1  block can accept input this cycle
in_code  in  N+1  bits [N:1] = Hamming positions 1..N (parity at powers of 2); bit 0 = overall parity
out_valid  out  1  output word valid
out_ready  in  1  consumer accepts output this cycle
out_code  out  N+1  corrected codeword, same layout as in_code
out_data  out  K  data bits, non-power-of-2 positions in ascending order, lowest position at bit 0
out_syndrome  out  R  syndrome of the received word
out_err  out  1  syndrome nonzero
out_dbl_err  out  1  uncorrectable double error (DED build only, else 0)
err_count  out  CNT_W  count of words delivered with out_err=1, saturating
clr_count  in  1  synchronous counter clear

Behaviour:
- Reset (rst_n low, asynchronous): all pipeline valid flags 0, all data/syndrome registers 0, err_count 0. Outputs read 0; in_ready reads 1 after reset.
- Syndrome bit j = XOR of in_code[i] over all i in 1..N with bit j of i set.
- Stage 1 registers code and syndrome. Stage 2 registers corrected code, data, flags. Latency 2 cycles from accepted input to out_valid, with no stalls.
- Correction mask: one-hot over positions 1..N, position = syndrome; syndrome 0 gives all-zero mask and no flip.
- Bit 0 is never corrected in SEC builds; it passes through unchanged.
- Handshake:
  - Transfer on valid&&ready.
  - Stage k loads when it is empty or its contents move forward in the same cycle. in_ready = !v1 || !v2 || out_ready.
  - Full throughput is 1 word/cycle.
  - out_valid and all out_* stay stable while out_valid && !out_ready.
  - A word is never dropped or duplicated.
- Back-pressure: with out_ready low, both stages fill and in_ready drops. One cycle after out_ready returns, throughput resumes.
- err_count:
  - Increments by 1 on each output transfer with out_err=1.
  - Holds at 2^CNT_W-1.
  - clr_count sets it to 0 next edge. Clear wins over a simultaneous increment.
- Reset mid-operation discards in-flight words; no output transfer occurs for them.

Optional Feature:
HAMM_DED_EN
- Defined:
  - Overall parity P = XOR of in_code[N:0].
  - Syndrome≠0 and P=1: single error, correct as above.
  - Syndrome=0 and P=1: bit 0 error; flip bit 0, out_err=1.
  - Syndrome≠0 and P=0: out_dbl_err=1, out_err=1, no bits flipped.
  - err_count counts every word with out_err=1.
- Undefined: bit 0 is ignored for detection and out_dbl_err is tied 0.

Decomposition:
- Package hamming_pkg: functions par_bits_to_n(R) and par_bits_to_k(R); function is_pow2(i); typedef for syndrome width.
- One sub-module: hamming_onehot_dec, parametrised R-to-N one-hot decoder with zero input giving an all-zero output. It is the generalised replacement of the fixed 3-to-7 decoder.

Test Plan (PAR_BITS=3, CNT_W=8):
- in_code=8'hCC, out_ready=1 → 2 cycles later out_code=8'hCC, out_data=4'b1101, out_syndrome=0, out_err=0, err_count=0.
- in_code=8'hEC (bit 5 flipped) → out_syndrome=3'b101, out_code=8'hCC, out_data=4'b1101, out_err=1, err_count=1.
- Back-to-back stream of 5 words with out_ready held low 4 cycles → in_ready low after 2 accepts; all 5 words emerge in order, each held stable while stalled.
- 255 erroneous words, then 2 more → err_count=255 (saturated). clr_count pulsed concurrently with an erroneous transfer → err_count=0.
- in_code=8'hCA (bits 1,2 flipped):
  - DED build → out_syndrome=3'b011, out_dbl_err=1, out_code=8'hCA.
  - SEC build → out_code=8'hC2 (miscorrection of bit 3).
- rst_n asserted while both stages valid → out_valid=0 and err_count=0 immediately (asynchronously); no transfer after release until new input.
